id_ex_register: RTL and testbench
=================================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC, operand and immediate fields.
REQ-002 Parameter CNT_W, default 16, width of each event counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  load-use hazard from hazard detection unit; inserts a bubble into EX.
REQ-006 flush  input  1  taken-branch kill; clears the EX slot.
REQ-007 hold  input  1  global freeze (memory wait); EX slot keeps its current contents.
REQ-008 regwrite_id, memread_id, memwrite_id, alusrc_id, branch_id, memtoreg_id  input  1 each  decoded control from ID.
REQ-009 aluop_id  input  2  ALU operation class from ID.
REQ-010 pc_id, rs1_data_id, rs2_data_id, imm_id  input  XLEN each  ID datapath fields.
REQ-011 rs1_id, rs2_id, rd_id  input  5 each  register indices; funct3_id input 3; funct7b5_id input 1.
REQ-012 Each *_id input SHALL have a matching registered *_ex output of identical width.
REQ-013 valid_ex  output  1  EX slot holds a real instruction.
REQ-014 bubble_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-015 Per-cycle update priority SHALL be: rst > flush > hold > stall > load.
REQ-016 load (no rst/flush/hold/stall): every *_ex output SHALL take its *_id input next edge; valid_ex SHALL become 1; latency exactly one cycle.
REQ-017 stall (hold=0, flush=0): every *_ex output SHALL become 0 and valid_ex SHALL become 0 (bubble); ID inputs are discarded by this block.
REQ-018 flush: every *_ex output and valid_ex SHALL become 0 regardless of hold and stall.
REQ-019 hold (flush=0): every *_ex output and valid_ex SHALL retain its value; stall is ignored while hold=1.
REQ-020 A bubble or flush SHALL zero rd_ex and all control outputs so no register write, memory access or branch occurs in EX.
REQ-021 bubble_cnt SHALL increment by 1 on each edge where stall=1, hold=0, flush=0, rst=0.
REQ-022 flush_cnt SHALL increment by 1 on each edge where flush=1, rst=0.
REQ-023 Counters SHALL saturate at all-ones and never wrap.
REQ-024 Consecutive stall cycles SHALL each insert a bubble and each count once.
REQ-025 Deassertion of hold with stall=1 SHALL insert a bubble on that same edge.
REQ-026 No output SHALL depend combinationally on any input.

Reset
REQ-027 On a rising edge with rst=1, every *_ex output, valid_ex, bubble_cnt and flush_cnt SHALL become 0.
REQ-028 rst SHALL override flush, hold and stall, including in the middle of a held or stalled sequence.
REQ-029 Outputs are undefined only before the first reset edge; one reset cycle SHALL suffice.

Structure
REQ-030 A shared package rv32_pkg SHALL hold XLEN, register-index width 5, ALUOP encodings (00 load/store add, 01 branch, 10 R-type, 11 I-type) and the control bundle width 8.
REQ-031 Control fields SHALL be handled as one 8-bit bundle internally so bubble/flush clearing is a single assignment.
REQ-032 One sub-module sat_counter (parameter width, inputs clk, rst, inc; output count) SHALL implement both counters.

Verification
REQ-033 rst=1 one cycle, then load pc_id=0x100, rd_id=5, regwrite_id=1, aluop_id=10 -> next edge pc_ex=0x100, rd_ex=5, regwrite_ex=1, valid_ex=1.
REQ-034 stall=1 for 3 cycles with memread_id=1, rd_id=7 -> valid_ex=0, rd_ex=0, memread_ex=0 each cycle; bubble_cnt=3.
REQ-035 Load instruction A (pc 0x200), then hold=1 for 4 cycles with changing ID inputs and stall=1 -> pc_ex stays 0x200, valid_ex=1; bubble_cnt unchanged.
REQ-036 hold=1, flush=1, stall=1 on the same edge -> all *_ex=0, valid_ex=0, flush_cnt=1, bubble_cnt=0.
REQ-037 CNT_W=4, stall=1 for 20 cycles -> bubble_cnt reaches 15 and stays 15.
REQ-038 Mid-hold with valid_ex=1 and bubble_cnt=2, assert rst=1 with flush=1 -> next edge all outputs 0, flush_cnt=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions.
//   XLEN       : datapath width (PC, operands, immediate)
//   REG_W      : register index width
//   CTRL_W     : width of the decoded control bundle
//   ALUOP_*    : ALU operation class encodings
//   ctrl_t     : decoded control bundle, handled as one 8-bit word
package rv32_pkg;
    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 8;

    localparam logic [1:0] ALUOP_LS  = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       branch;
        logic       memtoreg;
        logic [1:0] aluop;
    } ctrl_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   rst   : synchronous active-high reset, clears count
//   inc   : add one on this edge (ignored once count is all-ones)
//   count : current value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {WIDTH{1'b1}}))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with bubble insertion, flush, hold and event counters.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : load-use bubble into EX
//   flush             : taken-branch kill of the EX slot
//   hold              : global freeze, EX slot keeps its contents
//   *_id              : decoded control and datapath fields from ID
//   *_ex              : registered copies for EX
//   valid_ex          : EX slot holds a real instruction
//   bubble_cnt        : saturating count of inserted bubbles
//   flush_cnt         : saturating count of flushes
// Update priority: rst > flush > hold > stall > load.
module id_ex_register
    import rv32_pkg::*;
#(
    parameter int XLEN  = rv32_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             hold,
    input  logic             regwrite_id,
    input  logic             memread_id,
    input  logic             memwrite_id,
    input  logic             alusrc_id,
    input  logic             branch_id,
    input  logic             memtoreg_id,
    input  logic [1:0]       aluop_id,
    input  logic [XLEN-1:0]  pc_id,
    input  logic [XLEN-1:0]  rs1_data_id,
    input  logic [XLEN-1:0]  rs2_data_id,
    input  logic [XLEN-1:0]  imm_id,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic [REG_W-1:0] rd_id,
    input  logic [2:0]       funct3_id,
    input  logic             funct7b5_id,
    output logic             regwrite_ex,
    output logic             memread_ex,
    output logic             memwrite_ex,
    output logic             alusrc_ex,
    output logic             branch_ex,
    output logic             memtoreg_ex,
    output logic [1:0]       aluop_ex,
    output logic [XLEN-1:0]  pc_ex,
    output logic [XLEN-1:0]  rs1_data_ex,
    output logic [XLEN-1:0]  rs2_data_ex,
    output logic [XLEN-1:0]  imm_ex,
    output logic [REG_W-1:0] rs1_ex,
    output logic [REG_W-1:0] rs2_ex,
    output logic [REG_W-1:0] rd_ex,
    output logic [2:0]       funct3_ex,
    output logic             funct7b5_ex,
    output logic             valid_ex,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    ctrl_t ctrl_id, ctrl_q;

    assign ctrl_id = '{regwrite: regwrite_id, memread: memread_id,
                       memwrite: memwrite_id, alusrc: alusrc_id,
                       branch: branch_id, memtoreg: memtoreg_id,
                       aluop: aluop_id};

    // Bubble and flush both clear the whole slot, so control, rd and
    // datapath fields all go to zero together.
    logic clear;
    assign clear = flush || (!hold && stall);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ctrl_q      <= '0;
            pc_ex       <= '0;
            rs1_data_ex <= '0;
            rs2_data_ex <= '0;
            imm_ex      <= '0;
            rs1_ex      <= '0;
            rs2_ex      <= '0;
            rd_ex       <= '0;
            funct3_ex   <= '0;
            funct7b5_ex <= 1'b0;
            valid_ex    <= 1'b0;
        end else if (!hold) begin
            ctrl_q      <= ctrl_id;
            pc_ex       <= pc_id;
            rs1_data_ex <= rs1_data_id;
            rs2_data_ex <= rs2_data_id;
            imm_ex      <= imm_id;
            rs1_ex      <= rs1_id;
            rs2_ex      <= rs2_id;
            rd_ex       <= rd_id;
            funct3_ex   <= funct3_id;
            funct7b5_ex <= funct7b5_id;
            valid_ex    <= 1'b1;
        end
    end

    assign regwrite_ex = ctrl_q.regwrite;
    assign memread_ex  = ctrl_q.memread;
    assign memwrite_ex = ctrl_q.memwrite;
    assign alusrc_ex   = ctrl_q.alusrc;
    assign branch_ex   = ctrl_q.branch;
    assign memtoreg_ex = ctrl_q.memtoreg;
    assign aluop_ex    = ctrl_q.aluop;

    // A stall masked by hold or flush is not a bubble.
    logic bubble_inc;
    assign bubble_inc = stall && !hold && !flush;

    sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );
endmodule

// File: tb/tb_id_ex_register.sv
module tb_id_ex_register;
    localparam int XLEN = 32;
    localparam int VW   = 4*XLEN + 15 + 3 + 1 + 8 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, stall, flush, hold;
    logic regwrite_id, memread_id, memwrite_id, alusrc_id, branch_id, memtoreg_id;
    logic [1:0] aluop_id;
    logic [XLEN-1:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic [2:0] funct3_id;
    logic funct7b5_id;

    logic regwrite_ex, memread_ex, memwrite_ex, alusrc_ex, branch_ex, memtoreg_ex;
    logic [1:0] aluop_ex;
    logic [XLEN-1:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0] rs1_ex, rs2_ex, rd_ex;
    logic [2:0] funct3_ex;
    logic funct7b5_ex, valid_ex;
    logic [15:0] bubble_cnt, flush_cnt;

    // Second instance with narrow counters, only its counters are observed.
    logic regwrite_4, memread_4, memwrite_4, alusrc_4, branch_4, memtoreg_4;
    logic [1:0] aluop_4;
    logic [XLEN-1:0] pc_4, rs1_data_4, rs2_data_4, imm_4;
    logic [4:0] rs1_4, rs2_4, rd_4;
    logic [2:0] funct3_4;
    logic funct7b5_4, valid_4;
    logic [3:0] bubble_cnt4, flush_cnt4;

    id_ex_register #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .hold(hold),
        .regwrite_id(regwrite_id), .memread_id(memread_id), .memwrite_id(memwrite_id),
        .alusrc_id(alusrc_id), .branch_id(branch_id), .memtoreg_id(memtoreg_id),
        .aluop_id(aluop_id), .pc_id(pc_id), .rs1_data_id(rs1_data_id),
        .rs2_data_id(rs2_data_id), .imm_id(imm_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .funct3_id(funct3_id), .funct7b5_id(funct7b5_id),
        .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
        .alusrc_ex(alusrc_ex), .branch_ex(branch_ex), .memtoreg_ex(memtoreg_ex),
        .aluop_ex(aluop_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex),
        .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .funct3_ex(funct3_ex), .funct7b5_ex(funct7b5_ex),
        .valid_ex(valid_ex), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_register #(.XLEN(XLEN), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .hold(hold),
        .regwrite_id(regwrite_id), .memread_id(memread_id), .memwrite_id(memwrite_id),
        .alusrc_id(alusrc_id), .branch_id(branch_id), .memtoreg_id(memtoreg_id),
        .aluop_id(aluop_id), .pc_id(pc_id), .rs1_data_id(rs1_data_id),
        .rs2_data_id(rs2_data_id), .imm_id(imm_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .funct3_id(funct3_id), .funct7b5_id(funct7b5_id),
        .regwrite_ex(regwrite_4), .memread_ex(memread_4), .memwrite_ex(memwrite_4),
        .alusrc_ex(alusrc_4), .branch_ex(branch_4), .memtoreg_ex(memtoreg_4),
        .aluop_ex(aluop_4), .pc_ex(pc_4), .rs1_data_ex(rs1_data_4),
        .rs2_data_ex(rs2_data_4), .imm_ex(imm_4), .rs1_ex(rs1_4), .rs2_ex(rs2_4),
        .rd_ex(rd_4), .funct3_ex(funct3_4), .funct7b5_ex(funct7b5_4),
        .valid_ex(valid_4), .bubble_cnt(bubble_cnt4), .flush_cnt(flush_cnt4)
    );

    // Whole EX slot as one word: fields then valid in the LSB.
    logic [VW-1:0] in_vec, ex_vec;
    assign in_vec = {pc_id, rs1_data_id, rs2_data_id, imm_id, rs1_id, rs2_id, rd_id,
                     funct3_id, funct7b5_id, regwrite_id, memread_id, memwrite_id,
                     alusrc_id, branch_id, memtoreg_id, aluop_id, 1'b1};
    assign ex_vec = {pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rs1_ex, rs2_ex, rd_ex,
                     funct3_ex, funct7b5_ex, regwrite_ex, memread_ex, memwrite_ex,
                     alusrc_ex, branch_ex, memtoreg_ex, aluop_ex, valid_ex};

    int checks = 0;
    int errors = 0;

    // Reference model: the slot contents and plain integer event counts.
    logic [VW-1:0] m_vec;
    int m_bub, m_fl;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic rand_id();
        {regwrite_id, memread_id, memwrite_id, alusrc_id, branch_id, memtoreg_id} = 6'($urandom);
        aluop_id    = 2'($urandom);
        pc_id       = $urandom;
        rs1_data_id = $urandom;
        rs2_data_id = $urandom;
        imm_id      = $urandom;
        rs1_id      = 5'($urandom);
        rs2_id      = 5'($urandom);
        rd_id       = 5'($urandom);
        funct3_id   = 3'($urandom);
        funct7b5_id = 1'($urandom);
    endtask

    task automatic zero_id();
        {regwrite_id, memread_id, memwrite_id, alusrc_id, branch_id, memtoreg_id} = '0;
        aluop_id = '0; pc_id = '0; rs1_data_id = '0; rs2_data_id = '0; imm_id = '0;
        rs1_id = '0; rs2_id = '0; rd_id = '0; funct3_id = '0; funct7b5_id = 1'b0;
    endtask

    // One clock edge: advance the model from the specified priority rules,
    // then compare the whole slot and all counters just after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_vec = '0; m_bub = 0; m_fl = 0;
        end else begin
            if (flush) m_fl++;
            if (stall && !hold && !flush) m_bub++;
            if (flush)      m_vec = '0;
            else if (hold)  m_vec = m_vec;
            else if (stall) m_vec = '0;
            else            m_vec = in_vec;
        end
        #1;
        chk("slot", ex_vec, m_vec);
        chk("bubble_cnt", VW'(bubble_cnt), VW'(sat(m_bub, 65535)));
        chk("flush_cnt", VW'(flush_cnt), VW'(sat(m_fl, 65535)));
        chk("bubble_cnt4", VW'(bubble_cnt4), VW'(sat(m_bub, 15)));
        chk("flush_cnt4", VW'(flush_cnt4), VW'(sat(m_fl, 15)));
    endtask

    task automatic ctl(input logic r, input logic s, input logic f, input logic h);
        rst = r; stall = s; flush = f; hold = h;
    endtask

    initial begin
        m_vec = '0; m_bub = 0; m_fl = 0;
        zero_id();
        ctl(1, 0, 0, 0);
        tick();
        chk("reset_valid", VW'(valid_ex), '0);

        // Basic load
        ctl(0, 0, 0, 0);
        pc_id = 32'h100; rd_id = 5'd5; regwrite_id = 1'b1; aluop_id = 2'b10;
        tick();
        chk("load_pc", VW'(pc_ex), VW'(32'h100));
        chk("load_rd", VW'(rd_ex), VW'(5));
        chk("load_regwrite", VW'(regwrite_ex), VW'(1));
        chk("load_valid", VW'(valid_ex), VW'(1));

        // Three consecutive bubbles
        ctl(0, 1, 0, 0);
        memread_id = 1'b1; rd_id = 5'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", VW'(valid_ex), '0);
            chk("stall_rd", VW'(rd_ex), '0);
            chk("stall_memread", VW'(memread_ex), '0);
        end
        chk("stall_bubble3", VW'(bubble_cnt), VW'(3));

        // Hold keeps instruction A while ID churns and stall is asserted
        ctl(0, 0, 0, 0);
        rand_id(); pc_id = 32'h200;
        tick();
        ctl(0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            rand_id();
            tick();
            chk("hold_pc", VW'(pc_ex), VW'(32'h200));
            chk("hold_valid", VW'(valid_ex), VW'(1));
        end
        chk("hold_bubble", VW'(bubble_cnt), VW'(3));

        // Releasing hold with stall high bubbles on that edge
        ctl(0, 1, 0, 0);
        tick();
        chk("unhold_valid", VW'(valid_ex), '0);
        chk("unhold_bubble", VW'(bubble_cnt), VW'(4));

        // flush beats hold and stall
        ctl(1, 0, 0, 0); tick();
        ctl(0, 0, 0, 0); rand_id(); tick();
        ctl(0, 1, 1, 1); rand_id(); tick();
        chk("flush_slot", ex_vec, '0);
        chk("flush_cnt1", VW'(flush_cnt), VW'(1));
        chk("flush_bubble0", VW'(bubble_cnt), '0);

        // Saturation of the narrow counter
        ctl(1, 0, 0, 0); tick();
        ctl(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            rand_id();
            tick();
            if (i == 14) chk("sat_reach15", VW'(bubble_cnt4), VW'(15));
        end
        chk("sat_stay15", VW'(bubble_cnt4), VW'(15));
        chk("wide_20", VW'(bubble_cnt), VW'(20));

        // Reset in the middle of a hold overrides flush
        ctl(1, 0, 0, 0); tick();
        ctl(0, 1, 0, 0); tick(); tick();
        ctl(0, 0, 0, 0); rand_id(); tick();
        ctl(0, 0, 0, 1); rand_id(); tick();
        chk("pre_rst_valid", VW'(valid_ex), VW'(1));
        chk("pre_rst_bubble", VW'(bubble_cnt), VW'(2));
        ctl(1, 1, 1, 1); tick();
        chk("rst_slot", ex_vec, '0);
        chk("rst_flush_cnt", VW'(flush_cnt), '0);
        chk("rst_bubble_cnt", VW'(bubble_cnt), '0);

        // Random mix of all controls against the model
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(99) < 3);
            flush = ($urandom_range(99) < 10);
            hold  = ($urandom_range(99) < 25);
            stall = ($urandom_range(99) < 30);
            rand_id();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
